// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the scoreboard hazard controller: pipeline sizes, stage,
// source-use, forward-select and result-latency codes.
package hazard_pkg;

    localparam int NREG     = 32;
    localparam int RW       = 5;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int MD_W     = $clog2(DIV_LAT + 1);

    // Stage a pending producer currently occupies
    typedef enum logic [1:0] {
        POS_E = 2'd0,
        POS_M = 2'd1,
        POS_W = 2'd2
    } pos_t;

    // Stage in which a D-stage instruction consumes a source operand
    typedef enum logic [1:0] {
        NEED_NONE = 2'd0,
        NEED_D    = 2'd1,
        NEED_E    = 2'd2
    } need_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_W  = 2'd1,
        FWD_M  = 2'd2
    } fwd_t;

    // Stage at the end of which a producer's result becomes available
    typedef enum logic [1:0] {
        LAT_M = 2'd1,
        LAT_W = 2'd2
    } lat_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D/E-stage hazard bus between the pipeline control and the scoreboard.
// The pipeline side is the master; the scoreboard is the slave.
interface hazard_scoreboard_if;
    import hazard_pkg::*;

    logic [RW-1:0] d_rs;
    logic [RW-1:0] d_rt;
    logic [1:0]    d_need_rs;
    logic [1:0]    d_need_rt;
    logic          d_we;
    logic [RW-1:0] d_wreg;
    logic [1:0]    d_lat;
    logic          d_mdop;
    logic          e_md_start;
    logic          e_md_div;
    logic          flush;

    logic          stall;
    logic [1:0]    fwd_d_rs;
    logic [1:0]    fwd_d_rt;
    logic [1:0]    fwd_e_rs;
    logic [1:0]    fwd_e_rt;
    logic          md_busy;
    logic [31:0]   stall_cnt;

    modport master (
        output d_rs, d_rt, d_need_rs, d_need_rt, d_we, d_wreg, d_lat,
               d_mdop, e_md_start, e_md_div, flush,
        input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy, stall_cnt
    );

    modport slave (
        input  d_rs, d_rt, d_need_rs, d_need_rt, d_we, d_wreg, d_lat,
               d_mdop, e_md_start, e_md_div, flush,
        output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy, stall_cnt
    );

endinterface

// File: rtl/hazard_scoreboard_md_counter.sv
// Multiply/divide busy counter: loads the unit latency when an op starts in E
// and counts down to zero; busy while non-zero.
module hazard_md_counter
    import hazard_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    output logic busy
);

    logic [MD_W-1:0] cnt_p0;

    // Stage 0: remaining busy cycles (reset discards an in-flight op)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_p0 <= '0;
        end else if (start) begin
            cnt_p0 <= div ? MD_W'(DIV_LAT) : MD_W'(MULT_LAT);
        end else if (cnt_p0 != '0) begin
            cnt_p0 <= cnt_p0 - MD_W'(1);
        end
    end

    assign busy = (cnt_p0 != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard/forwarding controller for the 5-stage pipeline.
// Optional stall-cycle counter is built when HAZ_STALL_CNT_EN is defined.
module hazard_scoreboard
    import hazard_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    hazard_scoreboard_if.slave  bus
);

    logic [NREG-1:0] pend_p0;
    logic [NREG-1:0] pend_nxt;
    pos_t            pos_p0 [NREG];
    logic [1:0]      rdy_p0 [NREG];

    logic       rs_live, rt_live;
    logic       rs_stall, rt_stall, md_stall;
    logic       stall, issue, wr_en;
    logic       md_busy;
    logic [1:0] fwd_e_rs_p1, fwd_e_rt_p1;

    function automatic logic src_live(input logic pend, input logic [RW-1:0] r,
                                      input logic [1:0] need);
        return pend && (r != '0) && ((need == NEED_D) || (need == NEED_E));
    endfunction

    // A source consumed in E gets one extra cycle for its producer to advance
    function automatic logic src_stall(input logic live, input pos_t pos,
                                       input logic [1:0] rdy, input logic [1:0] need);
        logic [2:0] at_use;
        at_use = {1'b0, pos} + ((need == NEED_E) ? 3'd1 : 3'd0);
        return live && (at_use < {1'b0, rdy});
    endfunction

    function automatic logic [1:0] stage_fwd(input logic [2:0] stage);
        case (stage)
            3'd1:    return FWD_M;
            3'd2:    return FWD_W;
            default: return FWD_RF;
        endcase
    endfunction

    always_comb begin
        rs_live  = src_live(pend_p0[bus.d_rs], bus.d_rs, bus.d_need_rs);
        rt_live  = src_live(pend_p0[bus.d_rt], bus.d_rt, bus.d_need_rt);
        rs_stall = src_stall(rs_live, pos_p0[bus.d_rs], rdy_p0[bus.d_rs], bus.d_need_rs);
        rt_stall = src_stall(rt_live, pos_p0[bus.d_rt], rdy_p0[bus.d_rt], bus.d_need_rt);
        md_stall = bus.d_mdop && (md_busy || bus.e_md_start);
        stall    = rs_stall || rt_stall || md_stall;
        issue    = !stall && !bus.flush;
        wr_en    = issue && bus.d_we && (bus.d_wreg != '0);
    end

    // Entries at W retire; flush drops the E and M producers; a new issue wins
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            pend_nxt[i] = pend_p0[i] && (pos_p0[i] != POS_W) && !bus.flush;
        end
        if (wr_en) begin
            pend_nxt[bus.d_wreg] = 1'b1;
        end
    end

    // Stage 0: pending flags and E-stage forward selects
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_p0     <= '0;
            fwd_e_rs_p1 <= FWD_RF;
            fwd_e_rt_p1 <= FWD_RF;
        end else begin
            pend_p0     <= pend_nxt;
            fwd_e_rs_p1 <= (issue && rs_live)
                           ? stage_fwd({1'b0, pos_p0[bus.d_rs]} + 3'd1) : FWD_RF;
            fwd_e_rt_p1 <= (issue && rt_live)
                           ? stage_fwd({1'b0, pos_p0[bus.d_rt]} + 3'd1) : FWD_RF;
        end
    end

    // Stage 0: producer position/latency, meaningful only where pend_p0 is set
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (wr_en && (bus.d_wreg == RW'(i))) begin
                pos_p0[i] <= POS_E;
                rdy_p0[i] <= bus.d_lat;
            end else begin
                case (pos_p0[i])
                    POS_E:   pos_p0[i] <= POS_M;
                    POS_M:   pos_p0[i] <= POS_W;
                    default: pos_p0[i] <= POS_W;
                endcase
            end
        end
    end

    hazard_md_counter u_md_counter (
        .clk   (clk),
        .reset (reset),
        .start (bus.e_md_start),
        .div   (bus.e_md_div),
        .busy  (md_busy)
    );

`ifdef HAZ_STALL_CNT_EN
    logic [31:0] stall_cnt_p0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_p0 <= '0;
        end else if (stall && !bus.flush) begin
            stall_cnt_p0 <= stall_cnt_p0 + 32'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_p0;
`else
    assign bus.stall_cnt = 32'd0;
`endif

    assign bus.stall    = stall;
    assign bus.fwd_d_rs = rs_live ? stage_fwd({1'b0, pos_p0[bus.d_rs]}) : FWD_RF;
    assign bus.fwd_d_rt = rt_live ? stage_fwd({1'b0, pos_p0[bus.d_rt]}) : FWD_RF;
    assign bus.fwd_e_rs = fwd_e_rs_p1;
    assign bus.fwd_e_rt = fwd_e_rt_p1;
    assign bus.md_busy  = md_busy;

endmodule
